sync_fifo_fwft: RTL

Parametrised synchronous first-word-fall-through FIFO; next generation of the thermometer's 8-bit, 16-entry sample buffer. Adds configurable width and depth, an occupancy count, and programmable almost-full/almost-empty thresholds. Optional sticky overflow/underflow error flags are also available. Sits between the sensor sample path (writer) and the display/UART consumer (reader) in a single clock domain.

---
 rtl/sync_fifo_fwft_pkg.sv | 25 ++
 rtl/sync_fifo_fwft_if.sv | 31 +++
 rtl/sync_fifo_fwft_mem.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 112 +++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared types, width helpers and default parameters for the sync_fifo_fwft slice.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned FIFO_AE_DEF    = 2;

  // Pointer width: enough bits to address DEPTH entries (minimum 1).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width: enough bits to hold 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Handshake/data bundle between the FIFO (slave) and its writer/reader (master).
interface sync_fifo_fwft_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) ();

  logic                     write;
  logic [WIDTH-1:0]         wr_data;
  logic                     read;
  logic [WIDTH-1:0]         rd_data;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [cnt_w(DEPTH)-1:0]  count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output write, wr_data, read,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write, wr_data, read,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_fwft_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic [ptr_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]        rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the write word; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count and
// almost-full/almost-empty thresholds.
// Optional macro FIFO_ERR_FLAGS_EN builds sticky overflow/underflow flags;
// without it those outputs are tied low.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH    = FIFO_DEPTH_DEF,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = FIFO_AE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_fwft_if.slave  bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo_fwft: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
    $error("sync_fifo_fwft: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_ae_chk
    $error("sync_fifo_fwft: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fifo_flags_t      flags_q, flags_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Accept/drop decisions and next-state pointers, count and flags.
  always_comb begin
    wr_acc   = bus.write && (!flags_q.full || bus.read);
    rd_acc   = bus.read && !flags_q.empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    flags_d.full         = (count_d == CW'(DEPTH));
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= CW'(AF_LEVEL));
    flags_d.almost_empty = (count_d <= CW'(AE_LEVEL));
  end

  // Register pointers, count and flags; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= fifo_flags_t'{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  // Reset gates the store so a write coinciding with reset leaves nothing behind.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign bus.rd_data      = flags_q.empty ? '0 : mem_rdata;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags: set on a dropped write or ignored read, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write && !wr_acc) overflow_q  <= 1'b1;
      if (bus.read  && !rd_acc) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
